// File: rtl/bitstream_pkg.sv
// Shared types and constants for the bitstream frame sequencer.
//   state_t           : frame sequencer states
//   LFSR_TAPS         : feedback tap mask (bits 0,3,12,14,15), shift right, feedback into MSB
//   SEED_BASE_DEFAULT : default base seed, lane i seed = base + 16'h0101*(i+1)
package bitstream_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_TAPS         = 16'hD009;
    localparam logic [15:0] SEED_BASE_DEFAULT = 16'h001A;

    // Per-lane seed; base must be chosen so that no lane seed is zero.
    function automatic logic [15:0] lane_seed(input logic [15:0] base, input int unsigned lane);
        return base + 16'(32'h0101 * (lane + 1));
    endfunction

endpackage

// File: rtl/bitstream_frame_sequencer_if.sv
// Request/response handshake bundle between host and frame sequencer.
//   req_valid/req_ready/req_value : operand request (lane i = bits [i*(WIDTH+1) +: WIDTH+1])
//   res_valid/res_ready/res_count : ones-count response
//   master : host side, slave : sequencer side
interface bitstream_frame_sequencer_if #(
    parameter int unsigned NUM_IN = 2,
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned WINDOW = 256
);
    localparam int unsigned VW = NUM_IN * (WIDTH + 1);
    localparam int unsigned CW = $clog2(WINDOW + 1);

    logic          req_valid;
    logic          req_ready;
    logic [VW-1:0] req_value;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_count;

    modport master (
        output req_valid, req_value, res_ready,
        input  req_ready, res_valid, res_count
    );

    modport slave (
        input  req_valid, req_value, res_ready,
        output req_ready, res_valid, res_count
    );
endinterface

// File: rtl/bitstream_lane_gen.sv
// One operand lane: seeded LFSR compared against the operand value.
//   clk, n_rst : clock, async active-low reset (loads seed)
//   load       : reseed LFSR
//   advance    : step LFSR one position
//   seed       : lane seed
//   value      : operand, 0..2**WIDTH
//   bit_c      : combinational stochastic bit, lfsr top WIDTH bits < value
module bitstream_lane_gen
    import bitstream_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LFSR_LEN = 16
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                load,
    input  logic                advance,
    input  logic [LFSR_LEN-1:0] seed,
    input  logic [WIDTH:0]      value,
    output logic                bit_c
);
    localparam logic [LFSR_LEN-1:0] TAPS = LFSR_LEN'(LFSR_TAPS);

    logic [LFSR_LEN-1:0] lfsr;
    logic                fb;

    assign fb = ^(lfsr & TAPS);

    // Fibonacci LFSR, shifting right with feedback into the MSB.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lfsr <= seed;
        end else if (load) begin
            lfsr <= seed;
        end else if (advance) begin
            lfsr <= {fb, lfsr[LFSR_LEN-1:1]};
        end
    end

    // WIDTH+1-bit compare so value 2**WIDTH always yields 1.
    assign bit_c = ({1'b0, lfsr[LFSR_LEN-1 -: WIDTH]} < value);

endmodule

// File: rtl/bitstream_frame_sequencer.sv
// Sequences one stochastic-computing frame: latches operands, streams WINDOW
// bits per lane into the network, counts ones on the returned bitstream
// (delayed by PIPE_LAT) and returns the count.
//   clk, n_rst : clock, async active-low reset
//   bus        : request/response handshake (slave side)
//   abort      : synchronous frame abort, ignored in IDLE
//   bs_out     : per-lane bitstreams to the network
//   bs_valid   : bs_out carries a frame bit
//   bs_in      : result bitstream from the network
//   busy       : not IDLE
module bitstream_frame_sequencer
    import bitstream_pkg::*;
#(
    parameter int unsigned NUM_IN    = 2,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned LFSR_LEN  = 16,
    parameter int unsigned WINDOW    = 256,
    parameter int unsigned PIPE_LAT  = 0,
    parameter logic [15:0] SEED_BASE = SEED_BASE_DEFAULT
) (
    input  logic                       clk,
    input  logic                       n_rst,
    bitstream_frame_sequencer_if.slave bus,
    input  logic                       abort,
    output logic [NUM_IN-1:0]          bs_out,
    output logic                       bs_valid,
    input  logic                       bs_in,
    output logic                       busy
);
    localparam int unsigned CW      = $clog2(WINDOW + 1);
    localparam int unsigned CNT_MAX = (WINDOW > PIPE_LAT) ? WINDOW : PIPE_LAT;
    localparam int unsigned NW      = $clog2(CNT_MAX + 1);
    localparam int unsigned DRAIN_LAST = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

    state_t                        state, state_next;
    logic [NW-1:0]                 cnt;
    logic [CW-1:0]                 cap_cnt, cap_nxt;
    logic [NUM_IN-1:0][WIDTH:0]    val_q;
    logic [NUM_IN-1:0]             lane_bit_c;
    logic                          dvalid;
    logic                          abort_act;

    assign abort_act = abort && (state != IDLE);

    // Next-state logic; abort overrides everything outside IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (bus.req_valid)                state_next = LOAD;
            LOAD:                                    state_next = RUN;
            RUN:   if (cnt == NW'(WINDOW - 1))       state_next = (PIPE_LAT > 0) ? DRAIN : DONE;
            DRAIN: if (cnt == NW'(DRAIN_LAST))       state_next = DONE;
            DONE:  if (bus.res_ready)                state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
        if (abort_act) begin
            state_next = IDLE;
        end
    end

    // Capture counter, cleared in LOAD, saturating at WINDOW.
    always_comb begin
        cap_nxt = cap_cnt;
        if (state == LOAD) begin
            cap_nxt = '0;
        end else if (dvalid && bs_in && (cap_cnt != CW'(WINDOW))) begin
            cap_nxt = cap_cnt + CW'(1);
        end
    end

    // State, counters and registered outputs (decoded from next state).
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state         <= IDLE;
            cnt           <= '0;
            cap_cnt       <= '0;
            val_q         <= '0;
            bus.req_ready <= 1'b1;
            bus.res_valid <= 1'b0;
            bus.res_count <= '0;
            bs_valid      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_next;
            cap_cnt       <= cap_nxt;
            bus.req_ready <= (state_next == IDLE);
            bus.res_valid <= (state_next == DONE);
            bs_valid      <= (state_next == RUN);
            busy          <= (state_next != IDLE);
            if (state == IDLE && bus.req_valid) begin
                val_q <= bus.req_value;
            end
            // cap_nxt already includes the final captured bit.
            if (state != DONE && state_next == DONE) begin
                bus.res_count <= cap_nxt;
            end
            case (state)
                LOAD:    cnt <= '0;
                RUN:     cnt <= (state_next == DRAIN) ? '0 : cnt + NW'(1);
                DRAIN:   cnt <= cnt + NW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // bs_valid delayed by the network latency.
    if (PIPE_LAT == 0) begin : g_nopipe
        assign dvalid = bs_valid;
    end else begin : g_pipe
        logic [PIPE_LAT-1:0] vpipe;
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                vpipe <= '0;
            end else if (abort_act) begin
                vpipe <= '0;
            end else begin
                vpipe <= PIPE_LAT'({vpipe, bs_valid});
            end
        end
        assign dvalid = vpipe[PIPE_LAT-1];
    end

    for (genvar i = 0; i < NUM_IN; i++) begin : g_lane
        bitstream_lane_gen #(
            .WIDTH    (WIDTH),
            .LFSR_LEN (LFSR_LEN)
        ) u_lane (
            .clk     (clk),
            .n_rst   (n_rst),
            .load    (state == LOAD),
            .advance (state == RUN),
            .seed    (LFSR_LEN'(lane_seed(SEED_BASE, i))),
            .value   (val_q[i]),
            .bit_c   (lane_bit_c[i])
        );
    end

    assign bs_out = bs_valid ? lane_bit_c : '0;

endmodule

// File: doc/bitstream_frame_sequencer.md
Name: bitstream_frame_sequencer

Overview:
- Sequences one stochastic-computing evaluation frame for the bitstream network.
- Accepts a vector of binary operand values through a valid/ready request.
- Converts each operand to a unary bitstream using per-lane LFSR comparators, drives the bitstreams into the network for WINDOW cycles, and counts the ones on the network's result bitstream, allowing for the network pipeline latency.
- Returns the count as a binary result through a valid/ready response.
- Sits between the host/test controller and the bitstream network.

Parameters:
- NUM_IN, 2: number of operand lanes (≥1).
- WIDTH, 8: comparator width; operand value range is 0..2**WIDTH.
- LFSR_LEN, 16: LFSR length; fixed feedback taps 0,3,12,14,15; shift right; feedback enters the MSB.
- WINDOW, 256: bitstream length per frame (≥2).
- PIPE_LAT, 0: network latency in cycles from bs_out/bs_valid to bs_in.
- SEED_BASE, 16'h001A: lane i seed = SEED_BASE + 16'h0101*(i+1); must never be zero.

Ports:
- clk, input, 1: clock.
- n_rst, input, 1: asynchronous active-low reset.
- req_valid, input, 1: operand request valid.
- req_ready, output, 1: sequencer can accept a request.
- req_value, input, NUM_IN*(WIDTH+1): packed operands; lane i is bits [i*(WIDTH+1) +: WIDTH+1].
- abort, input, 1: synchronous frame abort.
- bs_out, output, NUM_IN: operand bitstreams to the network.
- bs_valid, output, 1: bs_out carries a frame bit this cycle.
- bs_in, input, 1: result bitstream from the network.
- res_valid, output, 1: result count valid.
- res_ready, input, 1: consumer accepts the result.
- res_count, output, CW = $clog2(WINDOW+1): number of ones captured.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (async, n_rst low):
  - State IDLE.
  - req_ready=1; bs_out=0, bs_valid=0; res_valid=0, res_count=0, busy=0.
  - LFSRs loaded with their seeds; counters and the latency pipe cleared.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - req_valid&req_ready → latch all lane values, go to LOAD.
- LOAD (1 cycle):
  - Reseed every lane LFSR to its seed; clear the emit counter and capture counter.
  - Frames are therefore bit-reproducible.
- RUN:
  - bs_valid=1.
  - bs_out[i] = (lfsr_i[LFSR_LEN-1 -: WIDTH] < value_i), using a WIDTH+1-bit unsigned compare. value 0 → always 0; value 2**WIDTH → always 1.
  - LFSRs advance once per RUN cycle; the first RUN cycle uses the seed state.
  - Emit counter increments each cycle; after WINDOW bits, go to DRAIN (PIPE_LAT>0) or DONE (PIPE_LAT=0).
- Capture:
  - bs_valid is delayed PIPE_LAT cycles (shift register; a wire if 0).
  - When the delayed valid=1 and bs_in=1, the capture counter increments, saturating at WINDOW.
  - Captured bits outside the delayed-valid window are ignored.
- DRAIN:
  - bs_valid=0, bs_out=0.
  - Wait exactly PIPE_LAT cycles so the last emitted bit is captured, then go to DONE.
- DONE:
  - res_valid=1; res_count = capture count, registered and stable while res_valid=1.
  - res_valid&res_ready → IDLE in the next cycle; res_valid drops.
  - req_ready=0 until IDLE is reached. No request is accepted in the same cycle as the response handshake.
- Latency: request accept → res_valid = 1 (LOAD) + WINDOW + PIPE_LAT + 1 cycles.
- abort:
  - In LOAD/RUN/DRAIN/DONE → IDLE next cycle.
  - bs_valid=0, res_valid=0, latency pipe cleared, res_count unchanged.
  - Ignored in IDLE.
  - abort has priority over a simultaneous res_ready.
- Reset mid-frame behaves exactly as power-on reset. There is no partial result.
- req_value changes after acceptance have no effect.

Decomposition:
- Shared package bitstream_pkg: state enum (IDLE, LOAD, RUN, DRAIN, DONE), the LFSR tap constant, and the default seed constant.
- One sub-module, bitstream_lane_gen: one lane.
  - Ports: clk, n_rst, load, advance, seed, value.
  - Output: registered LFSR feeding a combinational compare bit.
  - Instantiated NUM_IN times via generate.

Test Plan:
1. NUM_IN=2, PIPE_LAT=0, bs_in tied to bs_out[0]; value0=0, value1=256 → res_count=0; bs_out[1]=1 on all 256 bs_valid cycles; res_valid exactly 258 cycles after the accept.
2. value0=256, PIPE_LAT=3, bs_in = bs_out[0] delayed 3 cycles → res_count=256; res_valid 261 cycles after the accept; DRAIN lasts 3 cycles.
3. value0=128, bs_in=bs_out[0], run two back-to-back frames → both res_count equal the software LFSR model count (identical, proving reseed); req_ready=0 throughout each frame.
4. Frame done, res_ready held low 10 cycles then pulsed → res_valid and res_count stable for all 10 cycles; IDLE next cycle; req_ready returns 1.
5. abort asserted at RUN cycle 100 → bs_valid=0 the next cycle; IDLE, no res_valid; a following frame with value0=256 gives res_count=256.
6. n_rst pulsed low at RUN cycle 50 (asynchronous, mid-cycle) → all outputs take reset values immediately; a subsequent frame matches the model.
